// File: rtl/dram_pkg.sv
// Shared types, constants and byte helpers for the dram_pipelined storage block.
package dram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int MAX_READ_LATENCY = 4;
  localparam int MAX_DATA_WIDTH   = 256;
  localparam int MAX_BYTES        = MAX_DATA_WIDTH / 8;

  // Words narrower than MAX_DATA_WIDTH are zero-extended by the caller and cut back afterwards.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_BYTES-1:0]      be
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-return shift register of {valid, payload}; payload only advances with a valid entry,
// so the last stage holds the most recent result between pulses.
module dram_rd_pipe
  import dram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH < 1 || DEPTH > MAX_READ_LATENCY) begin : g_bad_depth
    $error("dram_rd_pipe: DEPTH must be 1..%0d", MAX_READ_LATENCY);
  end

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic             stage_valid_reg;
    logic [WIDTH-1:0] stage_data_reg;

    if (gi == 0) begin : g_first
      assign v_in = in_valid;
      assign d_in = in_data;
    end else begin : g_next
      assign v_in = valid_q[gi-1];
      assign d_in = data_q[gi-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_valid_reg <= 1'b0;
        stage_data_reg  <= '0;
      end else begin
        stage_valid_reg <= v_in;
        if (v_in) stage_data_reg <= d_in;
      end
    end

    assign valid_q[gi] = stage_valid_reg;
    assign data_q[gi]  = stage_data_reg;
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/dram_pipelined.sv
// Simple-dual-port RAM: byte-enable writes, write-first bypass, READ_LATENCY-deep read return,
// optional clear sweep after reset. Define DRAM_PARITY_EN for per-byte even parity storage.
module dram_pipelined
  import dram_pkg::*;
#(
  parameter int    ADDR_WIDTH     = 8,
  parameter int    DATA_WIDTH     = 32,
  parameter int    READ_LATENCY   = 1,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string FILE           = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ready,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr_write,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   addr_read,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rvalid
`ifdef DRAM_PARITY_EN
  ,
  input  logic                    parity_inject,
  output logic                    parity_err
`endif
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $error("dram_pipelined: DATA_WIDTH must be a multiple of 8, at most %0d", MAX_DATA_WIDTH);
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("dram_pipelined: READ_LATENCY must be 1..%0d", MAX_READ_LATENCY);
  end
  if (CLEAR_ON_RESET != 0 && FILE != "") begin : g_bad_init
    $error("dram_pipelined: FILE image would be wiped by CLEAR_ON_RESET");
  end

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt_reg, clr_cnt_next;
  logic                  ready_reg;
  logic                  clr_we;
  logic                  wr_fire, rd_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      ready_reg   <= (state_next == READY);
    end
  end

  // The sweep must not touch address 0 on clock edges seen while reset is still held.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    clr_we       = 1'b0;
    case (state_reg)
      CLEAR: begin
        clr_we       = ~rst;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == LAST_ADDR) state_next = READY;
      end
      READY:   state_next = READY;
      default: state_next = READY;
    endcase
  end

  assign ready   = ready_reg;
  assign wr_fire = we & ready_reg & (|be);
  assign rd_fire = re & ready_reg;

  logic [NB-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_reg] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr_write][i] <= data_in[i*8 +: 8];
      end
    end
  end

  // Write-first: bytes being written this cycle to the read address come straight from data_in.
  logic [NB-1:0]         byp_be;
  logic [DATA_WIDTH-1:0] rd_word;

  assign byp_be  = (wr_fire && (addr_write == addr_read)) ? be : '0;
  assign rd_word = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(mem[addr_read]),
                                          MAX_DATA_WIDTH'(data_in),
                                          MAX_BYTES'(byp_be)));

`ifdef DRAM_PARITY_EN
  localparam int PW = DATA_WIDTH + 1;

  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wr_par, rd_par, rd_err_bits;

  for (genvar gi = 0; gi < NB; gi++) begin : g_par
    assign wr_par[gi]      = byte_parity(data_in[gi*8 +: 8]) ^ parity_inject;
    assign rd_par[gi]      = byp_be[gi] ? wr_par[gi] : par_mem[addr_read][gi];
    assign rd_err_bits[gi] = byte_parity(rd_word[gi*8 +: 8]) ^ rd_par[gi];
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[clr_cnt_reg] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) par_mem[addr_write][i] <= wr_par[i];
      end
    end
  end
`else
  localparam int PW = DATA_WIDTH;
`endif

  // Pipe payload is {err, data} with parity, plain data otherwise.
  logic [PW-1:0] pipe_in, pipe_out;

`ifdef DRAM_PARITY_EN
  assign pipe_in    = {|rd_err_bits, rd_word};
  assign data_out   = pipe_out[DATA_WIDTH-1:0];
  assign parity_err = pipe_out[DATA_WIDTH] & rvalid;
`else
  assign pipe_in  = rd_word;
  assign data_out = pipe_out;
`endif

  dram_rd_pipe #(
    .WIDTH(PW),
    .DEPTH(READ_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_fire),
    .in_data  (pipe_in),
    .out_valid(rvalid),
    .out_data (pipe_out)
  );

endmodule

// File: tb/tb_dram_pipelined.sv
// Randomised self-checking bench for dram_pipelined against a word-array reference model.
module tb_dram_pipelined;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int LAT   = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready, rvalid;
  logic          we = 1'b0, re = 1'b0;
  logic [NB-1:0] be = '0;
  logic [AW-1:0] addr_write = '0, addr_read = '0;
  logic [DW-1:0] data_in = '0, data_out;
`ifdef DRAM_PARITY_EN
  logic          parity_inject = 1'b0;
  logic          parity_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dram_pipelined #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1), .FILE("")
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .we(we), .be(be), .addr_write(addr_write), .data_in(data_in),
    .re(re), .addr_read(addr_read), .data_out(data_out), .rvalid(rvalid)
`ifdef DRAM_PARITY_EN
    , .parity_inject(parity_inject), .parity_err(parity_err)
`endif
  );

  // Reference model: word array, per-byte "bad parity" flags, queue of expected read returns.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          err;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [NB-1:0] model_bad [DEPTH];
  logic [DW-1:0] last_data = '0;
  int            rel_edges = 0;

  task automatic model_reset();
    pend.delete();
    last_data = '0;
    rel_edges = 0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_bad[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic w, input logic [NB-1:0] b, input logic [AW-1:0] aw,
                      input logic [DW-1:0] d, input logic r, input logic [AW-1:0] ar,
                      input logic inj);
    logic          acc, exp_valid, exp_err;
    logic [NB-1:0] byp;
    logic [DW-1:0] exp_data;
    rd_t           e;
    @(negedge clk);
    we = w; be = b; addr_write = aw; data_in = d; re = r; addr_read = ar;
`ifdef DRAM_PARITY_EN
    parity_inject = inj;
`endif
    acc = (rel_edges >= DEPTH);
    rel_edges++;
    if (acc && r) begin
      byp    = (w && aw == ar) ? b : '0;
      e.data = model_mem[ar];
      for (int i = 0; i < NB; i++) if (byp[i]) e.data[i*8 +: 8] = d[i*8 +: 8];
      e.err  = |((model_bad[ar] & ~byp) | (byp & {NB{inj}}));
      e.due  = rel_edges + LAT - 1;
      pend.push_back(e);
    end
    if (acc && w) begin
      for (int i = 0; i < NB; i++) begin
        if (b[i]) begin
          model_mem[aw][i*8 +: 8] = d[i*8 +: 8];
          model_bad[aw][i]        = inj;
        end
      end
    end
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_data  = last_data;
    exp_err   = 1'b0;
    if (pend.size() > 0 && pend[0].due == rel_edges) begin
      e         = pend.pop_front();
      exp_valid = 1'b1;
      exp_data  = e.data;
      exp_err   = e.err;
      last_data = e.data;
    end
    checks++;
    if (ready !== (rel_edges >= DEPTH)) begin
      errors++;
      $display("FAIL ready edge %0d: got %b want %b", rel_edges, ready, rel_edges >= DEPTH);
    end
    checks++;
    if (rvalid !== exp_valid) begin
      errors++;
      $display("FAIL rvalid edge %0d: got %b want %b", rel_edges, rvalid, exp_valid);
    end
    checks++;
    if (data_out !== exp_data) begin
      errors++;
      $display("FAIL data_out edge %0d: got %h want %h", rel_edges, data_out, exp_data);
    end
`ifdef DRAM_PARITY_EN
    checks++;
    if (parity_err !== exp_err) begin
      errors++;
      $display("FAIL parity_err edge %0d: got %b want %b", rel_edges, parity_err, exp_err);
    end
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
    idle(LAT);
  endtask

  // Random traffic while the sweep runs: nothing may be accepted or returned.
  task automatic sweep_with_traffic();
    for (int i = 0; i < DEPTH; i++)
      step(1'($urandom), NB'($urandom), AW'($urandom), $urandom, 1'b1, AW'($urandom), 1'b0);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    checks++;
    if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
    do_reset();
    sweep_with_traffic();
    read_all();
  endtask

  task automatic test_byte_enable();
    step(1'b1, 4'b1111, 4'd3, 32'hAABBCCDD, 1'b0, '0, 1'b0);
    step(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
    idle(LAT);
    step(1'b1, 4'b0000, 4'd3, 32'hFFFFFFFF, 1'b1, 4'd3, 1'b0);
    idle(LAT);
  endtask

  task automatic test_bypass();
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] a;
      a = AW'($urandom);
      step(1'b1, 4'b1111, a, $urandom, 1'b0, '0, 1'b0);
      step(1'b1, NB'($urandom_range(1, 14)), a, $urandom, 1'b1, a, 1'b0);
      step(1'b1, 4'b1111, a, $urandom, 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, '0, 1'b1, a, 1'b0);
      idle(LAT);
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 8; a++) step(1'b1, 4'b1111, AW'(a + 8), $urandom, 1'b0, '0, 1'b0);
    for (int a = 0; a < 8; a++) step(1'b0, '0, '0, '0, 1'b1, AW'(15 - a), 1'b0);
    idle(LAT);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      step(1'($urandom), NB'($urandom), AW'($urandom), $urandom, 1'($urandom), AW'($urandom), 1'b0);
    idle(LAT);
  endtask

  task automatic test_reset_midsweep();
    step(1'b1, 4'b1111, 4'd9, $urandom | 32'h1, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b0);
    idle(LAT - 1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL async_rvalid: got %b want 0", rvalid); end
    checks++;
    if (data_out !== '0) begin errors++; $display("FAIL async_data: got %h want 0", data_out); end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b want 0", ready); end
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, '0, '0, '0, 1'b1, AW'($urandom), 1'b0);
    do_reset();
    sweep_with_traffic();
    read_all();
  endtask

`ifdef DRAM_PARITY_EN
  task automatic test_parity();
    step(1'b1, 4'b1111, 4'd5, $urandom, 1'b0, '0, 1'b0);
    step(1'b1, 4'b0010, 4'd5, $urandom, 1'b0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
    step(1'b1, 4'b1111, 4'd6, $urandom, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd6, 1'b0);
    idle(LAT);
    step(1'b1, 4'b0100, 4'd7, $urandom, 1'b1, 4'd7, 1'b1);
    step(1'b1, 4'b0010, 4'd5, $urandom, 1'b1, 4'd5, 1'b0);
    idle(LAT);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_enable();
    test_bypass();
    test_back_to_back();
    test_random();
`ifdef DRAM_PARITY_EN
    test_parity();
`endif
    test_reset_midsweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_pipelined.md
# dram_pipelined

Parametrised simple-dual-port on-chip RAM: one write port with byte enables, one read port with a configurable read-pipeline depth and a valid strobe. An optional post-reset clear sweep zeroes the array. It is the general-purpose storage block for the datapath, covering register-file, scratchpad and buffer storage where a fixed one-cycle, full-word RAM is insufficient.

## Interface
- ADDR_WIDTH, 8, address bits; depth is exactly 2**ADDR_WIDTH entries
- DATA_WIDTH, 32, word width; must be a multiple of 8 (elaboration $error otherwise)
- READ_LATENCY, 1, cycles from read request to data; legal 1..4
- CLEAR_ON_RESET, 1, 1 = zero the whole array after every reset
- FILE, "", hex image loaded at time zero; non-empty FILE with CLEAR_ON_RESET=1 is an elaboration $error
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ready  output  1  array usable; requests ignored while 0
- we  input  1  write request
- be  input  DATA_WIDTH/8  byte enables for the write
- addr_write  input  ADDR_WIDTH  write address
- data_in  input  DATA_WIDTH  write data
- re  input  1  read request
- addr_read  input  ADDR_WIDTH  read address
- data_out  output  DATA_WIDTH  read data
- rvalid  output  1  data_out carries the result of a request
- parity_err  output  1  present only with DRAM_PARITY_EN

## Operation
- The FSM has two states, CLEAR and READY.
- While rst is high: state goes to CLEAR if CLEAR_ON_RESET=1, otherwise READY. ready=0, rvalid=0, data_out=0, parity_err=0, the read pipeline is flushed and the clear counter is 0.
- rst does not alter array contents, except through the clear sweep.
- CLEAR: one entry per cycle, addresses 0 to 2**ADDR_WIDTH-1, with all data and parity bits written to 0.
  - On the last address the state moves to READY.
  - we and re are ignored in CLEAR.
- Reset asserted mid-sweep restarts the sweep at address 0.
- READY: ready=1. we writes only the bytes with be[i]=1. we with be all zero is a no-op.
- Read-during-write to the same address in the same cycle is write-first:
  - enabled bytes come from data_in;
  - the other bytes come from the array.
- A read samples the array (plus bypass) in its request cycle. Writes after that cycle never change an in-flight read.
- Requests may issue every cycle; there is no backpressure.
- data_out holds its last value while rvalid=0.

## Timing
- A read request in cycle N gives data_out and rvalid=1 in cycle N+READY_LATENCY, i.e. N+READ_LATENCY. rvalid is a one-cycle pulse per request.
- A write in cycle N is visible to a read issued in cycle N (bypass) or later.
- The clear sweep takes 2**ADDR_WIDTH cycles after rst deasserts. ready rises on the following edge.
- With CLEAR_ON_RESET=0, ready rises on the first clk edge after rst deasserts.
- The async reset asserts outputs immediately. Deassertion is assumed synchronised externally.

## Configuration
- DRAM_PARITY_EN defined:
  - one even-parity bit is stored per byte, written alongside that byte;
  - on a read, the parity of each returned byte is recomputed;
  - parity_err is asserted with rvalid when any byte mismatches;
  - port parity_inject (input, 1) inverts the stored parity bits of the enabled bytes on a write, for test.
- DRAM_PARITY_EN undefined: no parity storage, no parity_err port, no parity_inject port. Behaviour is otherwise identical.

## Structure
- Package dram_pkg holds:
  - the state enum (CLEAR, READY);
  - the byte_merge(old, new, be) function;
  - the byte_parity function;
  - the MAX_READ_LATENCY=4 constant.
- Sub-module dram_rd_pipe: a READ_LATENCY-deep shift register of {valid, data, err} with async reset. It is instantiated once.

## Test plan
- CLEAR_ON_RESET=1, ADDR_WIDTH=4: release reset, then issue re every cycle.
  - Required: ready=0 for exactly 16 cycles.
  - Required: no rvalid during the sweep.
  - Required: afterwards every address reads 0.
- Write 0xAABBCCDD to addr 3 with be=4'b1111, then write 0x11223344 with be=4'b0101, then read addr 3.
  - Required: 0xAA22CC44 at exactly READ_LATENCY cycles after the read.
- Write and read the same address in the same cycle.
  - Required: the merged new data is returned.
  - Then write again while that read is in flight (READ_LATENCY=3). Required: the in-flight read keeps the old value.
- Back-to-back reads of 8 addresses with READ_LATENCY=4.
  - Required: 8 consecutive rvalid pulses, in order, with correct data.
- Assert rst at sweep address 7, then release.
  - Required: the sweep restarts at 0, takes the full 16 cycles, and rvalid=0/data_out=0 immediately on rst.
- DRAM_PARITY_EN: write with parity_inject=1 and be=4'b0010, then read.
  - Required: parity_err=1 aligned with rvalid.
  - A clean write and read gives parity_err=0.
